imem_boot_loader: RTL and testbench

- Sits directly upstream of the 5-stage RISC-V core. It loads program words into instruction memory before the core runs.
- Accepts a byte stream over a valid/ready handshake. Assembles each group of four bytes into a little-endian 32-bit instruction and issues one write per word to instruction memory.
- Holds the core in reset through `core_rst` until the load completes, then releases it.

---
 rtl/imem_boot_loader.sv | 125 ++++++++++++
 tb/tb_imem_boot_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes
// them to instruction memory and holds the core in reset until the image is complete.
module imem_boot_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic [7:0]        byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_e;

  localparam logic [ADDR_W:0] DepthW = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       buf_q, buf_d;
  logic              core_rst_q, core_rst_d;
  logic              err_q, err_d;
  logic              count_legal;
  logic              last_word;

  assign count_legal = (word_count_i != '0) && (word_count_i <= DepthW);
  // Compared in ADDR_W+1 bits so a full-depth load never needs the counter to wrap.
  assign last_word   = ({1'b0, wcnt_q} == (count_q - (ADDR_W+1)'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wcnt_q     <= '0;
      idx_q      <= '0;
      buf_q      <= '0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wcnt_q     <= wcnt_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wcnt_d     = wcnt_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    core_rst_d = core_rst_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_legal) begin
            err_d      = 1'b0;
            core_rst_d = 1'b1;
            count_d    = word_count_i;
            wcnt_d     = '0;
            idx_d      = '0;
            state_d    = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        // byte_ready is constant high here, so valid alone completes the handshake.
        if (byte_valid_i) begin
          buf_d[{idx_q, 3'b000} +: 8] = byte_in_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (last_word) begin
          state_d = DONE;
        end else begin
          wcnt_d  = wcnt_q + ADDR_W'(1);
          state_d = RECV;
        end
      end
      DONE: begin
        core_rst_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_ready_o = (state_q == RECV);
  assign imem_we_o    = (state_q == WRITE);
  assign imem_addr_o  = wcnt_q;
  assign imem_wdata_o = buf_q;
  assign core_rst_o   = core_rst_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader: a word-level vector table
// plus hand-written sequences for timing, illegal counts, busy, reset and full depth.
module tb_imem_boot_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef logic [0:3][7:0] bytes_t;

  typedef struct {
    bytes_t            bytesIn;
    bit                stall;
    logic [ADDR_W-1:0] expAddr;
    logic [31:0]       expData;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   wordCount = '0;
  logic [7:0]        byteIn = '0;
  logic              byteValid = 1'b0;
  logic              byteReady;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemWdata;
  logic              coreRst;
  logic              busy;
  logic              done;
  logic              err;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNo     = 0;
  int weCount     = 0;
  int weBase      = 0;
  int c           = 0;
  vec_t   vecs[4];
  bytes_t fullBytes;
  logic [31:0] fullExp;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clock),
    .rst_i        (reset),
    .start_i      (start),
    .word_count_i (wordCount),
    .byte_in_i    (byteIn),
    .byte_valid_i (byteValid),
    .byte_ready_o (byteReady),
    .imem_we_o    (imemWe),
    .imem_addr_o  (imemAddr),
    .imem_wdata_o (imemWdata),
    .core_rst_o   (coreRst),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleNo <= cycleNo + 1;

  // Write strobes are counted mid-cycle so stray writes show up in any test.
  always @(negedge clock) if (imemWe === 1'b1) weCount <= weCount + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulses start for one cycle in cycle c and returns with the bench in cycle c+1.
  task automatic applyStimulus(input logic [ADDR_W:0] wc, output int startCycle);
    start      = 1'b1;
    wordCount  = wc;
    startCycle = cycleNo;
    tick();
    start      = 1'b0;
    wordCount  = '0;
  endtask

  task automatic streamBytes(input bytes_t b, input int nBytes, input bit stall);
    int idx   = 0;
    int guard = 0;
    bit phase = 1'b0;
    bit acc;
    while (idx < nBytes && guard < 40) begin
      byteValid = stall ? phase : 1'b1;
      phase     = ~phase;
      byteIn    = b[idx];
      acc       = byteValid && (byteReady === 1'b1);
      tick();
      guard++;
      if (acc) idx++;
    end
    byteValid = 1'b0;
    byteIn    = '0;
    if (idx != nBytes) checkOutput("streamTimeout", 32'(idx), 32'(nBytes));
  endtask

  task automatic checkWrite(input string name, input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    checkOutput({name, "_we"}, 32'(imemWe), 32'd1);
    checkOutput({name, "_addr"}, 32'(imemAddr), 32'(addr));
    checkOutput({name, "_data"}, imemWdata, data);
    checkOutput({name, "_readyLow"}, 32'(byteReady), 32'd0);
  endtask

  initial begin
    vecs[0] = '{{8'h13, 8'h05, 8'h50, 8'h00}, 1'b1, 6'd0, 32'h00500513};
    vecs[1] = '{{8'h93, 8'h05, 8'hA0, 8'h00}, 1'b1, 6'd1, 32'h00A00593};
    vecs[2] = '{{8'hB3, 8'h06, 8'hB5, 8'h00}, 1'b0, 6'd2, 32'h00B506B3};
    vecs[3] = '{{8'hFF, 8'h00, 8'hAA, 8'h55}, 1'b1, 6'd3, 32'h55AA00FF};

    $display("[TB] Starting imem_boot_loader test");

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_coreRst", 32'(coreRst), 32'd1);
    checkOutput("rst_byteReady", 32'(byteReady), 32'd0);
    checkOutput("rst_imemWe", 32'(imemWe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_addr", 32'(imemAddr), 32'd0);
    checkOutput("rst_wdata", imemWdata, 32'd0);
    reset = 1'b0;
    tick();

    // Illegal counts from reset
    weBase = weCount;
    applyStimulus(7'd0, c);
    checkOutput("ill0_err", 32'(err), 32'd1);
    checkOutput("ill0_busy", 32'(busy), 32'd0);
    checkOutput("ill0_coreRst", 32'(coreRst), 32'd1);
    checkOutput("ill0_byteReady", 32'(byteReady), 32'd0);
    tick();
    applyStimulus(7'd65, c);
    checkOutput("ill65_err", 32'(err), 32'd1);
    checkOutput("ill65_busy", 32'(busy), 32'd0);
    checkOutput("ill65_coreRst", 32'(coreRst), 32'd1);
    tick();
    tick();
    checkOutput("ill_errSticky", 32'(err), 32'd1);
    checkOutput("ill_noWrites", 32'(weCount - weBase), 32'd0);

    // Legal single-word start clears err
    applyStimulus(7'd1, c);
    checkOutput("one_errCleared", 32'(err), 32'd0);
    checkOutput("one_busy", 32'(busy), 32'd1);
    checkOutput("one_byteReady", 32'(byteReady), 32'd1);
    streamBytes({8'hEF, 8'hBE, 8'hAD, 8'hDE}, 4, 1'b0);
    checkWrite("one_w0", 6'd0, 32'hDEADBEEF);
    tick();
    checkOutput("one_done", 32'(done), 32'd1);
    tick();
    checkOutput("one_coreRstLow", 32'(coreRst), 32'd0);
    checkOutput("one_idle", 32'(busy), 32'd0);

    // Illegal count after a good load leaves core_rst low
    applyStimulus(7'd65, c);
    checkOutput("illPost_err", 32'(err), 32'd1);
    checkOutput("illPost_coreRst", 32'(coreRst), 32'd0);
    tick();
    checkOutput("illPost_coreRstHold", 32'(coreRst), 32'd0);

    // Basic two-word load with exact latency
    applyStimulus(7'd2, c);
    checkOutput("basic_coreRst", 32'(coreRst), 32'd1);
    checkOutput("basic_err", 32'(err), 32'd0);
    checkOutput("basic_readyAtC1", 32'(byteReady), 32'd1);
    streamBytes({8'h13, 8'h05, 8'h50, 8'h00}, 4, 1'b0);
    checkOutput("basic_w0Cycle", 32'(cycleNo - c), 32'd5);
    checkWrite("basic_w0", 6'd0, 32'h00500513);
    tick();
    streamBytes({8'h93, 8'h05, 8'hA0, 8'h00}, 4, 1'b0);
    checkOutput("basic_w1Cycle", 32'(cycleNo - c), 32'd10);
    checkWrite("basic_w1", 6'd1, 32'h00A00593);
    tick();
    checkOutput("basic_doneCycle", 32'(cycleNo - c), 32'd11);
    checkOutput("basic_done", 32'(done), 32'd1);
    checkOutput("basic_coreRstAtDone", 32'(coreRst), 32'd1);
    tick();
    checkOutput("basic_coreRstLow", 32'(coreRst), 32'd0);
    checkOutput("basic_donePulse", 32'(done), 32'd0);
    checkOutput("basic_idle", 32'(busy), 32'd0);

    // Vector table: four-word load with stalled and continuous words
    applyStimulus(7'd4, c);
    for (int i = 0; i < 4; i++) begin
      streamBytes(vecs[i].bytesIn, 4, vecs[i].stall);
      checkWrite($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expData);
      tick();
      if (i < 3) checkOutput($sformatf("vec%0d_backToRecv", i), 32'(byteReady), 32'd1);
      else       checkOutput("vec_done", 32'(done), 32'd1);
    end
    tick();
    checkOutput("vec_coreRstLow", 32'(coreRst), 32'd0);

    // Start pulses while busy are ignored
    applyStimulus(7'd2, c);
    start     = 1'b1;
    wordCount = 7'd1;
    tick();
    wordCount = 7'd0;
    tick();
    start     = 1'b0;
    checkOutput("busy_noErr", 32'(err), 32'd0);
    checkOutput("busy_stillRecv", 32'(byteReady), 32'd1);
    streamBytes({8'h01, 8'h02, 8'h03, 8'h04}, 4, 1'b0);
    checkWrite("busy_w0", 6'd0, 32'h04030201);
    tick();
    checkOutput("busy_countKept", 32'(done), 32'd0);
    streamBytes({8'h11, 8'h22, 8'h33, 8'h44}, 4, 1'b0);
    checkWrite("busy_w1", 6'd1, 32'h44332211);
    tick();
    checkOutput("busy_done", 32'(done), 32'd1);
    tick();
    checkOutput("busy_coreRstLow", 32'(coreRst), 32'd0);

    // Reload after done re-asserts core_rst and restarts at address 0
    applyStimulus(7'd1, c);
    checkOutput("reload_coreRst", 32'(coreRst), 32'd1);
    streamBytes({8'h78, 8'h56, 8'h34, 8'h12}, 4, 1'b0);
    checkWrite("reload_w0", 6'd0, 32'h12345678);
    tick();
    checkOutput("reload_done", 32'(done), 32'd1);
    tick();
    checkOutput("reload_coreRstLow", 32'(coreRst), 32'd0);

    // Reset after six accepted bytes of a three-word load
    applyStimulus(7'd3, c);
    weBase = weCount;
    streamBytes({8'h0D, 8'hD0, 8'h0D, 8'hF0}, 4, 1'b0);
    checkWrite("mid_w0", 6'd0, 32'hF00DD00D);
    tick();
    streamBytes({8'hAA, 8'hBB, 8'hCC, 8'hDD}, 2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_coreRst", 32'(coreRst), 32'd1);
    checkOutput("mid_byteReady", 32'(byteReady), 32'd0);
    checkOutput("mid_wdataCleared", imemWdata, 32'd0);
    tick();
    tick();
    checkOutput("mid_oneWrite", 32'(weCount - weBase), 32'd1);
    applyStimulus(7'd1, c);
    streamBytes({8'h67, 8'h45, 8'h23, 8'h01}, 4, 1'b0);
    checkWrite("mid_fresh", 6'd0, 32'h01234567);
    tick();
    checkOutput("mid_freshDone", 32'(done), 32'd1);
    tick();
    checkOutput("mid_freshCoreRstLow", 32'(coreRst), 32'd0);

    // Full-depth load, preceded by the first illegal count above it
    applyStimulus(7'd65, c);
    checkOutput("full_ill65", 32'(err), 32'd1);
    applyStimulus(7'd64, c);
    checkOutput("full_errCleared", 32'(err), 32'd0);
    checkOutput("full_busy", 32'(busy), 32'd1);
    for (int w = 0; w < DEPTH; w++) begin
      fullBytes = {8'(w), 8'(w + 3), 8'(~w), 8'hA5};
      fullExp   = {8'hA5, 8'(~w), 8'(w + 3), 8'(w)};
      streamBytes(fullBytes, 4, 1'b0);
      checkWrite($sformatf("full_w%0d", w), 6'(w), fullExp);
      tick();
    end
    checkOutput("full_done", 32'(done), 32'd1);
    tick();
    checkOutput("full_coreRstLow", 32'(coreRst), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
